// File: rtl/mem_io_bridge_pkg.sv
// rtl/mem_io_bridge_pkg.sv - shared I/O map and read-source encodings for mem_io_bridge
package mem_io_bridge_pkg;

   localparam logic [17:0] IO_BASE = 18'h30000;
   localparam logic [2:0]  IO_UART = 3'd0;
   localparam logic [2:0]  IO_CLK  = 3'd4;

   // Source of mem_din for the cycle after an access
   localparam logic [1:0] SRC_ZERO = 2'd0;
   localparam logic [1:0] SRC_RAM  = 2'd1;
   localparam logic [1:0] SRC_RX   = 2'd2;
   localparam logic [1:0] SRC_CNT  = 2'd3;

   // Little-endian byte k of a 32-bit word
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// rtl/mem_io_bridge_tx_fifo.sv - circular tx byte FIFO with look-ahead count
module tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_next_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW-1:0]    count;
   logic             full, pop_ok, push_ok;

   // Occupancy; a push at full is only taken when a pop frees the slot in the same cycle
   always_comb begin
      count        = wr_q - rd_q;
      full         = (count == PW'(DEPTH));
      empty_o      = (count == '0);
      pop_ok       = pop_i & ~empty_o;
      push_ok      = push_i & (~full | pop_ok);
      wr_d         = wr_q + PW'(push_ok);
      rd_d         = rd_q + PW'(pop_ok);
      count_next_o = count + PW'(push_ok) - PW'(pop_ok);
      data_o       = mem_q[rd_q[AW-1:0]];
   end

   // Pointer state; reset empties the FIFO without touching storage
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Byte storage
   always_ff @(posedge clk_in) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU byte bus to RAM / UART / cycle-counter bridge
module mem_io_bridge
   import mem_io_bridge_pkg::*;
#(
   parameter int TX_DEPTH    = 16,
   parameter int FULL_MARGIN = 2,
   parameter int RAM_AW      = 17
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [31:0]       mem_a,
   input  logic [7:0]        mem_dout,
   input  logic              mem_wr,
   output logic [7:0]        mem_din,
   output logic              io_buffer_full,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_pop,
   output logic              program_done,
   output logic [31:0]       cycle_count
);

   localparam int          PW        = $clog2(TX_DEPTH) + 1;
   localparam logic [17:0] UART_ADDR = IO_BASE + 18'(IO_UART);
   localparam logic [17:0] CLK_ADDR  = IO_BASE + 18'(IO_CLK);

   logic          is_io, hit_uart, hit_clk0, hit_clk;
   logic          rd, wr_ok, push, pop;
   logic [7:0]    push_data;
   logic [PW-1:0] count_next;
   logic          fifo_empty;
   logic          unused_hi;

   logic [1:0]  src_q, src_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic [1:0]  cnt_idx_q, cnt_idx_d;
   logic [31:0] snapshot_q, snapshot_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic        stop_pending_q, stop_pending_d;
   logic        program_done_q, program_done_d;
   logic        io_full_q, io_full_d;

   assign unused_hi = ^mem_a[31:18];

   // Address decode and bus-side strobes; rdy_in gates every side effect
   always_comb begin
      is_io     = (mem_a[17:16] == 2'b11);
      hit_uart  = (mem_a[17:0] == UART_ADDR);
      hit_clk0  = (mem_a[17:0] == CLK_ADDR);
      hit_clk   = (mem_a[17:2] == CLK_ADDR[17:2]);
      rd        = ~mem_wr;
      wr_ok     = mem_wr & rdy_in;
      ram_addr  = mem_a[RAM_AW-1:0];
      ram_wdata = mem_dout;
      ram_we    = wr_ok & ~is_io;
      rx_pop    = rd & rdy_in & hit_uart & rx_valid;
      push      = wr_ok & ((hit_uart & (mem_dout != 8'h00)) | hit_clk0);
      push_data = hit_clk0 ? 8'h00 : mem_dout;
      pop       = tx_valid & tx_ready;
   end

   tx_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_i       (push),
      .data_i       (push_data),
      .pop_i        (pop),
      .data_o       (tx_data),
      .empty_o      (fifo_empty),
      .count_next_o (count_next)
   );

   assign tx_valid = ~fifo_empty;

   // Next-state: read-source select, I/O byte capture, snapshot, counter, stop tracking
   always_comb begin
      src_d       = SRC_ZERO;
      rx_byte_d   = rx_byte_q;
      cnt_idx_d   = cnt_idx_q;
      snapshot_d  = snapshot_q;
      if (rd) begin
         if (!is_io) begin
            src_d = SRC_RAM;
         end else if (hit_uart) begin
            src_d     = SRC_RX;
            rx_byte_d = rx_valid ? rx_data : 8'h00;
         end else if (hit_clk) begin
            src_d     = SRC_CNT;
            cnt_idx_d = mem_a[1:0];
            // byte 0 re-arms the snapshot so bytes 1..3 stay coherent with it
            if (hit_clk0) snapshot_d = cycle_count_q;
         end
      end
      cycle_count_d  = program_done_q ? cycle_count_q : cycle_count_q + 32'd1;
      stop_pending_d = stop_pending_q | (wr_ok & hit_clk0);
      // ordinary pushes are never 0x00, so a zero byte leaving while armed is the marker
      program_done_d = program_done_q | (pop & stop_pending_q & (tx_data == 8'h00));
      io_full_d      = (count_next >= PW'(TX_DEPTH - FULL_MARGIN));
   end

   // Registered state
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         src_q          <= SRC_ZERO;
         rx_byte_q      <= 8'h00;
         cnt_idx_q      <= 2'd0;
         snapshot_q     <= 32'd0;
         cycle_count_q  <= 32'd0;
         stop_pending_q <= 1'b0;
         program_done_q <= 1'b0;
         io_full_q      <= 1'b0;
      end else begin
         src_q          <= src_d;
         rx_byte_q      <= rx_byte_d;
         cnt_idx_q      <= cnt_idx_d;
         snapshot_q     <= snapshot_d;
         cycle_count_q  <= cycle_count_d;
         stop_pending_q <= stop_pending_d;
         program_done_q <= program_done_d;
         io_full_q      <= io_full_d;
      end
   end

   // Read return mux, one cycle after the address
   always_comb begin
      case (src_q)
         SRC_RAM: mem_din = ram_rdata;
         SRC_RX:  mem_din = rx_byte_q;
         SRC_CNT: mem_din = byte_of(snapshot_q, cnt_idx_q);
         default: mem_din = 8'h00;
      endcase
   end

   assign io_buffer_full = io_full_q;
   assign program_done   = program_done_q;
   assign cycle_count    = cycle_count_q;

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Sits directly downstream of the CPU top: consumes its byte-wide memory bus (mem_a, mem_dout, mem_wr) and produces mem_din and io_buffer_full. Decodes each access to either the 128 KB single-port RAM or the memory-mapped I/O window (mem_a[17:16]==2'b11). Owns the UART transmit FIFO, the UART receive pop, the cycle counter and the program-stop flag. All read data is returned exactly one cycle after the address, matching the CPU's one-cycle read contract.

Parameters:
TX_DEPTH, 16, UART tx FIFO entries (power of 2, >=4)
FULL_MARGIN, 2, free entries reserved for writes already in flight when io_buffer_full rises
RAM_AW, 17, RAM byte-address width

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
rdy_in  in  1  bus qualifier; when low, no side effects occur (no RAM write, FIFO push or rx pop)
mem_a  in  32  CPU address bus (only [17:0] decoded)
mem_dout  in  8  CPU write data
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data, valid the cycle after the address
io_buffer_full  out  1  tx FIFO near-full back-pressure to the CPU
ram_addr  out  RAM_AW  RAM byte address
ram_wdata  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  8  RAM read data, one cycle after ram_addr
tx_data  out  8  UART tx byte (FIFO head)
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  UART accepts tx_data this cycle
rx_data  in  8  UART rx byte
rx_valid  in  1  rx byte available
rx_pop  out  1  consume rx_data (one-cycle pulse)
program_done  out  1  sticky; stop marker fully drained to the UART
cycle_count  out  32  free-running cycle counter (debug)

Behaviour:
- Reset values: mem_din=0, io_buffer_full=0, ram_we=0, tx_valid=0, rx_pop=0, program_done=0, cycle_count=0. The FIFO is emptied and the stop_pending flag is cleared. Reset asserted mid-transfer discards FIFO contents immediately.
- Decode: is_io = mem_a[17:16]==2'b11. RAM accesses drive ram_addr=mem_a[RAM_AW-1:0] combinationally, with ram_we = mem_wr & rdy_in & ~is_io.
- Read return: the cycle-t source select (RAM, RX, CNT byte k, or ZERO) is registered. At t+1, mem_din is muxed from ram_rdata or a registered I/O byte. Latency is exactly 1 for every address.
- 0x30000 read: if rx_valid, return rx_data and pulse rx_pop for one cycle (gated by rdy_in). Otherwise return 0x00 with no pop.
- 0x30004..0x30007 read: return byte (a[1:0]) of the snapshot register, little-endian.
  - A read of 0x30004 loads the snapshot from cycle_count in the same cycle and returns byte 0 of the new value.
  - Bytes 1..3 come from the held snapshot, so a 4-byte read sequence is coherent.
- Other I/O reads return 0x00.
- 0x30000 write: push mem_dout if non-zero. A write of 0x00 is ignored.
- 0x30004 write: push 0x00 (the stop marker) and set stop_pending.
- Push when the FIFO is full: the byte is dropped and the pointers are unchanged. This is legal only if FULL_MARGIN has been violated.
- FIFO behaviour:
  - Circular buffer with ptr width clog2(TX_DEPTH)+1 and wrap at TX_DEPTH.
  - Simultaneous push and pop in the same cycle leaves count unchanged, and both take effect, including at full.
  - Pop occurs when tx_valid & tx_ready.
- io_buffer_full is registered: io_buffer_full <= (count_next >= TX_DEPTH-FULL_MARGIN).
- program_done is set the cycle after the stop marker is popped and is sticky until reset.
- cycle_count increments every clk_in edge while ~program_done (independent of rdy_in), wraps at 2^32, and freezes once program_done is set.
- rdy_in low blocks side effects only: mem_din timing is unchanged.

Decomposition:
- Shared package (def.v): IO_BASE=18'h30000, IO_UART=3'd0, IO_CLK=3'd4, and the mem_din source-select encodings SRC_RAM/SRC_RX/SRC_CNT/SRC_ZERO.
- One sub-module, tx_fifo (parameterised depth/width, push/pop/count/full/empty).
- Decode, read mux, snapshot, counter and stop logic stay in mem_io_bridge.

Test Plan:
- RAM write 0x5A to 0x00123, then read 0x00123 -> ram_we=1 for one cycle; mem_din=0x5A exactly one cycle after the read address.
- Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only; rx_pop never asserted.
- Hold tx_ready=0 and write 14 bytes (TX_DEPTH=16) -> io_buffer_full=1 the cycle after the 14th push; then release tx_ready -> it deasserts once count<14, with bytes delivered in order.
- Set rx_valid=1, rx_data=0x37 and read 0x30000 -> mem_din=0x37 next cycle and rx_pop pulses once. Read again with rx_valid=0 -> mem_din=0x00 and no pop.
- Run 0x1234 cycles after reset, then read 0x30004..0x30007 on consecutive cycles -> bytes equal the little-endian snapshot taken at the 0x30004 read, unaffected by later counting.
- Write to 0x30004 with 3 bytes queued and tx_ready=1 -> the 0x00 marker is emitted 4th, program_done=1 the next cycle, and cycle_count freezes. Assert rst_in asynchronously -> all outputs return to 0 immediately.
